// File: rtl/irq_ctrl_riscv.sv
// Machine-mode interrupt sequencer: samples level requests, picks the lowest
// enabled line, raises a trap pulse with mcause, waits for mret, then acks.
module irq_ctrl_riscv #(
  parameter int NUM_IRQ = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_IRQ-1:0] irq_req_i,
  input  logic [31:0]        mie_i,
  input  logic               exception_i,
  input  logic               mret_i,
  output logic               irq_o,
  output logic [31:0]        irq_cause_o,
  output logic [NUM_IRQ-1:0] irq_ret_o,
  output logic               busy_o
);

  localparam int IDW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  // Handshake: irq_o is a single-cycle request with irq_cause_o valid alongside
  // it; the core needs no ready, the trap is taken the same cycle. irq_ret_o is
  // a single-cycle one-hot strobe that peripherals must honour by dropping
  // their request line.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TRAP    = 2'd1,
    HANDLER = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t             state;
  logic [NUM_IRQ-1:0] irq_q;
  logic [NUM_IRQ-1:0] pending;
  logic [IDW-1:0]     id_q;
  logic [IDW-1:0]     sel;
  logic               any_pending;

  // Only mie[16 +: NUM_IRQ] matters; the rest of the CSR is consumed here.
  logic [31:0] unused_mie;
  assign unused_mie = mie_i;

  always_comb begin
    pending     = irq_q & mie_i[16 +: NUM_IRQ];
    any_pending = |pending;
    sel         = '0;
    // Scan downwards so the lowest set index is the one that sticks.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pending[i]) sel = IDW'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      irq_q <= '0;
      id_q  <= '0;
    end else begin
      irq_q <= irq_req_i;
      unique case (state)
        IDLE: begin
          if (any_pending && !exception_i) begin
            state <= TRAP;
            id_q  <= sel;
          end
        end
        TRAP:    state <= HANDLER;
        HANDLER: if (mret_i) state <= ACK;
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode from registered state, so reset clears outputs immediately.
  assign irq_o  = (state == TRAP);
  assign busy_o = (state != IDLE);

  always_comb begin
    irq_cause_o = '0;
    if (state == TRAP || state == HANDLER) begin
      irq_cause_o = 32'h8000_0000 | (32'd16 + 32'(id_q));
    end
  end

  always_comb begin
    irq_ret_o = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      irq_ret_o[i] = (state == ACK) && (id_q == IDW'(i));
    end
  end

endmodule

// File: tb/tb_irq_ctrl_riscv.sv
// Bench for irq_ctrl_riscv: directed scenarios plus random traffic checked
// against a transaction-level model of trap entry, service and acknowledge.
module tb_irq_ctrl_riscv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] req = '0;
  logic [31:0] mie = '0;
  logic        exc = 1'b0;
  logic        mret = 1'b0;
  logic        irq;
  logic [31:0] cause;
  logic [15:0] ret;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which phase of service we are in and which line is being served.
  localparam int M_IDLE = 0, M_TRAP = 1, M_HANDLER = 2, M_ACK = 3;
  int          m_phase = M_IDLE;
  int          m_id    = 0;
  logic [15:0] m_irq_q = '0;
  logic [15:0] exp_q[$];

  irq_ctrl_riscv #(.NUM_IRQ(16)) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .irq_req_i(req),
    .mie_i(mie),
    .exception_i(exc),
    .mret_i(mret),
    .irq_o(irq),
    .irq_cause_o(cause),
    .irq_ret_o(ret),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < 16; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_edge();
    logic [15:0] p;
    case (m_phase)
      M_IDLE: begin
        p = m_irq_q & mie[31:16];
        if (p != 0 && !exc) begin
          m_phase = M_TRAP;
          m_id    = lowest(p);
        end
      end
      M_TRAP: m_phase = M_HANDLER;
      M_HANDLER: if (mret) begin
        m_phase = M_ACK;
        exp_q.push_back(16'(1) << m_id);
      end
      default: m_phase = M_IDLE;
    endcase
    m_irq_q = req;
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_irq_q = '0;
    exp_q.delete();
  endtask

  task automatic compare_all();
    logic [31:0] e_cause;
    logic [15:0] e_ret;
    e_cause = (m_phase == M_TRAP || m_phase == M_HANDLER) ? 32'h8000_0000 + 32'(16 + m_id) : 32'h0;
    e_ret   = (m_phase == M_ACK) ? 16'(1) << m_id : 16'h0;
    check("irq", 32'(irq), 32'(m_phase == M_TRAP));
    check("cause", cause, e_cause);
    check("ret", 32'(ret), 32'(e_ret));
    check("busy", 32'(busy), 32'(m_phase != M_IDLE));
    if (ret !== 16'h0) begin
      if (exp_q.size() == 0) check("ret_unexpected", 32'(ret), 32'h0);
      else check("ret_scoreboard", 32'(ret), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  task automatic finish_irq();
    step();
    mret = 1'b1;
    step();
    mret = 1'b0;
    step();
  endtask

  initial begin
    #2;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_cause", cause, 32'h0);
    check("rst_ret", 32'(ret), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    step();
    rst_n = 1'b1;

    // Single interrupt on line 0.
    mie = 32'h0001_0000;
    req = 16'h0001;
    step();
    check("t1_latency", 32'(irq), 32'h0);
    step();
    check("t1_irq", 32'(irq), 32'h1);
    check("t1_cause", cause, 32'h8000_0010);
    check("t1_busy", 32'(busy), 32'h1);
    req = 16'h0;
    repeat (3) step();
    check("t1_wait_irq", 32'(irq), 32'h0);
    mret = 1'b1;
    step();
    mret = 1'b0;
    check("t1_ack", 32'(ret), 32'h0001);
    step();
    check("t1_idle", 32'(busy), 32'h0);

    // Priority and masking.
    req = 16'h0006;
    mie = 32'h0004_0000;
    step();
    step();
    check("prio_mask", cause, 32'h8000_0012);
    req = 16'h0;
    finish_irq();
    req = 16'h0006;
    mie = 32'h0006_0000;
    step();
    step();
    check("prio_low", cause, 32'h8000_0011);
    req = 16'h0;
    finish_irq();

    // Exception precedence.
    req = 16'h0008;
    mie = 32'h0008_0000;
    exc = 1'b1;
    step();
    check("exc_c1", 32'(irq), 32'h0);
    step();
    check("exc_c2", 32'(irq), 32'h0);
    exc = 1'b0;
    step();
    check("exc_trap", 32'(irq), 32'h1);
    check("exc_cause", cause, 32'h8000_0013);
    req = 16'h0;
    finish_irq();

    // No nesting.
    req = 16'h0020;
    mie = 32'h0021_0000;
    step();
    step();
    step();
    req = 16'h0021;
    step();
    step();
    check("nest_irq", 32'(irq), 32'h0);
    check("nest_cause", cause, 32'h8000_0015);
    req = 16'h0001;
    mret = 1'b1;
    step();
    mret = 1'b0;
    check("nest_ack", 32'(ret), 32'h0020);
    step();
    step();
    check("nest_next", cause, 32'h8000_0010);
    req = 16'h0;
    finish_irq();

    // Asynchronous reset while in the handler.
    req = 16'h0020;
    mie = 32'h0020_0000;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_cause", cause, 32'h0);
    check("arst_irq", 32'(irq), 32'h0);
    model_reset();
    step();
    rst_n = 1'b1;
    req = 16'h0;
    mret = 1'b1;
    repeat (3) step();
    check("arst_no_ack", 32'(ret), 32'h0);
    mret = 1'b0;

    // Requests only hitting bits outside the interrupt field of mie.
    req = 16'hFFFF;
    mie = 32'h0000_FFFF;
    repeat (20) begin
      step();
      check("masked_busy", 32'(busy), 32'h0);
    end
    req = 16'h0;
    step();

    // Random traffic.
    repeat (2000) begin
      req  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'h0;
      mie  = $urandom;
      exc  = ($urandom_range(0, 7) == 0);
      mret = ($urandom_range(0, 3) == 0);
      step();
    end
    req  = 16'h0;
    exc  = 1'b0;
    mret = 1'b1;
    repeat (6) step();
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
